serial_disp_rx: RTL

SERIAL_DISP_RX -- requirements
Module: serial_disp_rx

---
 rtl/serial_disp_rx.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/serial_disp_rx.sv
// serial_disp_rx: receives a shift-register style serial frame (s_clk / s_dat)
// terminated by a latch-enable rise on s_pen, and presents the last good frame
// on par_out. All pins are asynchronous to clk and are synchronized first.
module serial_disp_rx #(
  parameter int DATA_W    = 16,
  parameter int MSB_FIRST = 1,
  parameter int TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              RSTN,
  input  logic              s_clk,
  input  logic              s_dat,
  input  logic              s_pen,
  input  logic              s_clrn,
  output logic [DATA_W-1:0] par_out,
  output logic              frame_valid,
  output logic              frame_err,
  output logic [6:0]        bit_cnt,
  output logic              busy
);

  localparam int         TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT - 1);
  localparam logic [6:0] CNT_MAX = 7'(DATA_W + 1);
  localparam logic [6:0] CNT_FULL = 7'(DATA_W);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  // Pin bundle: bit 0 s_clk, bit 1 s_dat, bit 2 s_pen, bit 3 s_clrn
  logic [3:0] pins;
  logic [3:0] synced;
  assign pins = {s_clrn, s_pen, s_dat, s_clk};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      // Two-flop synchronizer for one pin
      always_ff @(posedge clk) begin
        if (!RSTN) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= pins[gi];
          sync_reg <= meta_reg;
        end
      end
      assign synced[gi] = sync_reg;
    end
  endgenerate

  logic       clk_prev_reg, pen_prev_reg;
  logic [1:0] fill_reg;
  logic       clk_armed_reg, pen_armed_reg;

  // Edge-detect history. The armed flags only come up once the synchronizer
  // holds a real low sample, so a pin already high at reset release never
  // produces an edge until it has gone low and risen again.
  always_ff @(posedge clk) begin
    if (!RSTN) begin
      clk_prev_reg  <= 1'b0;
      pen_prev_reg  <= 1'b0;
      fill_reg      <= 2'b00;
      clk_armed_reg <= 1'b0;
      pen_armed_reg <= 1'b0;
    end else begin
      clk_prev_reg  <= synced[0];
      pen_prev_reg  <= synced[2];
      fill_reg      <= {fill_reg[0], 1'b1};
      clk_armed_reg <= clk_armed_reg | (fill_reg[1] & ~synced[0]);
      pen_armed_reg <= pen_armed_reg | (fill_reg[1] & ~synced[2]);
    end
  end

  logic clk_edge, pen_edge, clr_active, dat;
  assign clk_edge   = synced[0] & ~clk_prev_reg & clk_armed_reg;
  assign pen_edge   = synced[2] & ~pen_prev_reg & pen_armed_reg;
  assign dat        = synced[1];
  assign clr_active = ~synced[3];

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   shift_reg, shift_next, shift_in;
  logic [DATA_W-1:0]   par_reg, par_next;
  logic [6:0]          cnt_reg, cnt_next, cnt_inc, cnt_eval;
  logic [TO_W-1:0]     to_reg, to_next;
  logic                valid_reg, valid_next, err_reg, err_next;

  assign shift_in = (MSB_FIRST != 0) ? {shift_reg[DATA_W-2:0], dat}
                                     : {dat, shift_reg[DATA_W-1:1]};
  assign cnt_inc  = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + 7'd1;

  // Next-state, datapath and pulse decisions
  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    par_next   = par_reg;
    cnt_next   = cnt_reg;
    cnt_eval   = cnt_reg;
    to_next    = to_reg;
    valid_next = 1'b0;
    err_next   = 1'b0;
    if (clr_active) begin
      state_next = IDLE;
      shift_next = '0;
      par_next   = '0;
      cnt_next   = '0;
      to_next    = '0;
    end else begin
      case (state_reg)
        IDLE, SHIFT: begin
          // A bit arriving together with s_pen is counted before judging
          if (clk_edge) begin
            shift_next = shift_in;
            cnt_next   = cnt_inc;
            cnt_eval   = cnt_inc;
            to_next    = '0;
          end else if (state_reg == SHIFT) begin
            to_next = to_reg + TO_W'(1);
          end
          if (pen_edge && (clk_edge || state_reg == SHIFT)) begin
            state_next = LATCH;
            if (cnt_eval == CNT_FULL) valid_next = 1'b1;
            else                      err_next   = 1'b1;
          end else if (pen_edge) begin
            err_next = 1'b1;      // latch with no bits received
          end else if (state_reg == SHIFT && !clk_edge && to_reg == TO_MAX) begin
            err_next   = 1'b1;
            state_next = IDLE;
            shift_next = '0;
            cnt_next   = '0;
            to_next    = '0;
          end else if (clk_edge) begin
            state_next = SHIFT;
          end
        end
        LATCH: begin
          if (valid_reg) par_next = shift_reg;
          state_next = IDLE;
          shift_next = '0;
          cnt_next   = '0;
          to_next    = '0;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!RSTN) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      par_reg   <= '0;
      cnt_reg   <= '0;
      to_reg    <= '0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      par_reg   <= par_next;
      cnt_reg   <= cnt_next;
      to_reg    <= to_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
    end
  end

  assign par_out     = par_reg;
  assign frame_valid = valid_reg;
  assign frame_err   = err_reg;
  assign bit_cnt     = cnt_reg;
  assign busy        = (state_reg == SHIFT);

endmodule
